// File: rtl/box_layer_engine.sv
// box_layer_engine: multi-box overlay renderer. Double-buffered box attributes
// commit on frame_start; every pixel is hit-tested against all boxes and the
// lowest-index hit box supplies the colour two cycles later. Boxes that
// overlap on a displayed pixel latch sticky per-frame collision flags.
module box_layer_engine #(
  parameter int unsigned NUM_BOXES = 4,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_BOXES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [2:0]           wr_sel,
  input  logic [COORD_W-1:0]   wr_data,
  input  logic                 frame_start,
  input  logic [COORD_W-1:0]   hpos,
  input  logic [COORD_W-1:0]   vpos,
  input  logic                 video_on,
  output logic                 pix_valid,
  output logic                 pix_hit,
  output logic [IDX_W-1:0]     pix_idx,
  output logic [COLOR_W-1:0]   pix_color,
  output logic [NUM_BOXES-1:0] hit_mask,
  output logic [NUM_BOXES-1:0] coll_flags,
  output logic                 coll_irq
);

  localparam int NB = int'(NUM_BOXES);

  // Shadow (CPU-visible) and active (rendering) attribute banks
  logic [COORD_W-1:0] r_sh_x  [NUM_BOXES];
  logic [COORD_W-1:0] r_sh_y  [NUM_BOXES];
  logic [COORD_W-1:0] r_sh_w  [NUM_BOXES];
  logic [COORD_W-1:0] r_sh_h  [NUM_BOXES];
  logic [COLOR_W-1:0] r_sh_c  [NUM_BOXES];
  logic               r_sh_en [NUM_BOXES];
  logic [COORD_W-1:0] r_ac_x  [NUM_BOXES];
  logic [COORD_W-1:0] r_ac_y  [NUM_BOXES];
  logic [COORD_W-1:0] r_ac_w  [NUM_BOXES];
  logic [COORD_W-1:0] r_ac_h  [NUM_BOXES];
  logic [COLOR_W-1:0] r_ac_c  [NUM_BOXES];
  logic               r_ac_en [NUM_BOXES];

  // Shadow contents after this cycle's write; also the commit source
  logic [COORD_W-1:0] w_nx_x  [NUM_BOXES];
  logic [COORD_W-1:0] w_nx_y  [NUM_BOXES];
  logic [COORD_W-1:0] w_nx_w  [NUM_BOXES];
  logic [COORD_W-1:0] w_nx_h  [NUM_BOXES];
  logic [COLOR_W-1:0] w_nx_c  [NUM_BOXES];
  logic               w_nx_en [NUM_BOXES];

  logic [NUM_BOXES-1:0] w_hit;
  logic [COLOR_W-1:0]   w_s1_color;
  logic [IDX_W-1:0]     w_s2_idx;
  logic                 w_multi;
  logic [NUM_BOXES-1:0] w_coll_nx;

  logic [NUM_BOXES-1:0] r_s1_hit;
  logic                 r_s1_vid;
  logic [COLOR_W-1:0]   r_s1_color;
  logic                 r_coll_any_d;

  // Decode the attribute write; out-of-range index or select matches no box
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_nx_x[b]  = r_sh_x[b];
      w_nx_y[b]  = r_sh_y[b];
      w_nx_w[b]  = r_sh_w[b];
      w_nx_h[b]  = r_sh_h[b];
      w_nx_c[b]  = r_sh_c[b];
      w_nx_en[b] = r_sh_en[b];
      if (wr_en && (wr_idx == IDX_W'(b))) begin
        case (wr_sel)
          3'd0:    w_nx_x[b]  = wr_data;
          3'd1:    w_nx_y[b]  = wr_data;
          3'd2:    w_nx_w[b]  = wr_data;
          3'd3:    w_nx_h[b]  = wr_data;
          3'd4:    w_nx_c[b]  = COLOR_W'(wr_data);
          3'd5:    w_nx_en[b] = wr_data[0];
          default: ;
        endcase
      end
    end
  end

  // Attribute banks: shadow always tracks writes, active loads at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        r_sh_x[b]  <= '0;
        r_sh_y[b]  <= '0;
        r_sh_w[b]  <= '0;
        r_sh_h[b]  <= '0;
        r_sh_c[b]  <= '0;
        r_sh_en[b] <= 1'b0;
        r_ac_x[b]  <= '0;
        r_ac_y[b]  <= '0;
        r_ac_w[b]  <= '0;
        r_ac_h[b]  <= '0;
        r_ac_c[b]  <= '0;
        r_ac_en[b] <= 1'b0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        r_sh_x[b]  <= w_nx_x[b];
        r_sh_y[b]  <= w_nx_y[b];
        r_sh_w[b]  <= w_nx_w[b];
        r_sh_h[b]  <= w_nx_h[b];
        r_sh_c[b]  <= w_nx_c[b];
        r_sh_en[b] <= w_nx_en[b];
        if (frame_start) begin
          r_ac_x[b]  <= w_nx_x[b];
          r_ac_y[b]  <= w_nx_y[b];
          r_ac_w[b]  <= w_nx_w[b];
          r_ac_h[b]  <= w_nx_h[b];
          r_ac_c[b]  <= w_nx_c[b];
          r_ac_en[b] <= w_nx_en[b];
        end
      end
    end
  end

  // Per-box hit test with wrapping offsets; colour of the winning box is
  // picked here so in-flight pixels keep the attributes they were tested with
  always_comb begin
    w_hit      = '0;
    w_s1_color = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      w_hit[b] = video_on && r_ac_en[b]
                 && (COORD_W'(hpos - r_ac_x[b]) < r_ac_w[b])
                 && (COORD_W'(vpos - r_ac_y[b]) < r_ac_h[b]);
      if (w_hit[b]) w_s1_color = r_ac_c[b];
    end
  end

  // Lowest set index of the stage-1 hit vector
  always_comb begin
    w_s2_idx = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (r_s1_hit[b]) w_s2_idx = IDX_W'(b);
    end
  end

  // Two or more boxes on the displayed pixel; frame start clears, new hits win
  always_comb begin
    w_multi   = |(hit_mask & NUM_BOXES'(hit_mask - NUM_BOXES'(1)));
    w_coll_nx = (frame_start ? '0 : coll_flags) | (w_multi ? hit_mask : '0);
  end

  // Two-stage pixel pipeline plus collision flags and interrupt pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_hit     <= '0;
      r_s1_vid     <= 1'b0;
      r_s1_color   <= '0;
      pix_valid    <= 1'b0;
      pix_hit      <= 1'b0;
      pix_idx      <= '0;
      pix_color    <= '0;
      hit_mask     <= '0;
      coll_flags   <= '0;
      r_coll_any_d <= 1'b0;
      coll_irq     <= 1'b0;
    end else begin
      r_s1_hit     <= w_hit;
      r_s1_vid     <= video_on;
      r_s1_color   <= w_s1_color;
      pix_valid    <= r_s1_vid;
      pix_hit      <= |r_s1_hit;
      pix_idx      <= w_s2_idx;
      pix_color    <= r_s1_color;
      hit_mask     <= r_s1_hit;
      coll_flags   <= w_coll_nx;
      r_coll_any_d <= |coll_flags;
      coll_irq     <= (|coll_flags) && !r_coll_any_d;
    end
  end

endmodule

// File: tb/tb_box_layer_engine.sv
// Bench for box_layer_engine: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_box_layer_engine;

  localparam int NB   = 3;
  localparam int CW   = 10;
  localparam int KW   = 8;
  localparam int IW   = 2;
  localparam int CMAX = 1 << CW;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [2:0]    wr_sel;
  logic [CW-1:0] wr_data;
  logic          frame_start;
  logic [CW-1:0] hpos;
  logic [CW-1:0] vpos;
  logic          video_on;
  logic          pix_valid;
  logic          pix_hit;
  logic [IW-1:0] pix_idx;
  logic [KW-1:0] pix_color;
  logic [NB-1:0] hit_mask;
  logic [NB-1:0] coll_flags;
  logic          coll_irq;

  box_layer_engine #(
    .NUM_BOXES(NB), .COORD_W(CW), .COLOR_W(KW), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_sel(wr_sel),
    .wr_data(wr_data), .frame_start(frame_start), .hpos(hpos), .vpos(vpos),
    .video_on(video_on), .pix_valid(pix_valid), .pix_hit(pix_hit),
    .pix_idx(pix_idx), .pix_color(pix_color), .hit_mask(hit_mask),
    .coll_flags(coll_flags), .coll_irq(coll_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  // Reference model: attribute tables indexed [box][0 x,1 y,2 w,3 h,4 colour,5 enable]
  int sh [NB][6];
  int ac [NB][6];
  // Expected pixel results one and two cycles after entry
  int p1_vid, p1_mask, p1_idx, p1_col;
  int p2_vid, p2_mask, p2_idx, p2_col;
  int m_coll, m_coll_old, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 6; a++) begin
        sh[b][a] = 0;
        ac[b][a] = 0;
      end
    p1_vid = 0; p1_mask = 0; p1_idx = 0; p1_col = 0;
    p2_vid = 0; p2_mask = 0; p2_idx = 0; p2_col = 0;
    m_coll = 0; m_coll_old = 0; m_irq = 0;
  endfunction

  // Which boxes cover (h,v) on screen, and the colour/index of the top one
  function automatic void eval_pixel(input int h, input int v, input int vid,
                                     output int mask, output int idx, output int col);
    bit found;
    mask = 0; idx = 0; col = 0; found = 0;
    for (int b = 0; b < NB; b++) begin
      int dx, dy;
      dx = (h - ac[b][0] + CMAX) % CMAX;
      dy = (v - ac[b][1] + CMAX) % CMAX;
      if (vid != 0 && ac[b][5] != 0 && dx < ac[b][2] && dy < ac[b][3]) begin
        mask = mask | (1 << b);
        if (!found) begin
          found = 1;
          idx = b;
          col = ac[b][4];
        end
      end
    end
  endfunction

  task automatic check_outputs(input string where);
    chk({where, ":pix_valid"},  32'(pix_valid),  32'(p2_vid));
    chk({where, ":pix_hit"},    32'(pix_hit),    32'(p2_mask != 0));
    chk({where, ":pix_idx"},    32'(pix_idx),    32'(p2_idx));
    chk({where, ":pix_color"},  32'(pix_color),  32'(p2_col));
    chk({where, ":hit_mask"},   32'(hit_mask),   32'(p2_mask));
    chk({where, ":coll_flags"}, 32'(coll_flags), 32'(m_coll));
    chk({where, ":coll_irq"},   32'(coll_irq),   32'(m_irq));
  endtask

  // One pixel clock: drive, advance the model across the edge, compare
  task automatic cyc(input int h, input int v, input int vid, input int fs,
                     input int we, input int widx, input int wsel, input int wdata);
    int m, ix, co, ncoll;
    hpos        = CW'(h);
    vpos        = CW'(v);
    video_on    = (vid != 0);
    frame_start = (fs != 0);
    wr_en       = (we != 0);
    wr_idx      = IW'(widx);
    wr_sel      = 3'(wsel);
    wr_data     = CW'(wdata);
    eval_pixel(h, v, vid, m, ix, co);
    @(posedge clk);
    #1;
    // Flags collect from the pixel on the outputs before this edge
    ncoll = (fs != 0) ? 0 : m_coll;
    if ($countones(p2_mask) >= 2) ncoll = ncoll | p2_mask;
    m_irq      = (m_coll != 0 && m_coll_old == 0) ? 1 : 0;
    m_coll_old = m_coll;
    m_coll     = ncoll;
    p2_vid = p1_vid; p2_mask = p1_mask; p2_idx = p1_idx; p2_col = p1_col;
    p1_vid = vid;    p1_mask = m;       p1_idx = ix;     p1_col = co;
    if (we != 0 && widx < NB && wsel < 6) begin
      if (wsel == 4)      sh[widx][wsel] = wdata % 256;
      else if (wsel == 5) sh[widx][wsel] = wdata % 2;
      else                sh[widx][wsel] = wdata % CMAX;
    end
    if (fs != 0)
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 6; a++) ac[b][a] = sh[b][a];
    check_outputs("cycle");
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fs();
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic pix(input int h, input int v);
    cyc(h, v, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int i, input int s, input int d);
    cyc(0, 0, 0, 0, 1, i, s, d);
  endtask

  task automatic box(input int i, input int x, input int y, input int w,
                     input int h, input int c, input int e);
    wr(i, 0, x); wr(i, 1, y); wr(i, 2, w); wr(i, 3, h); wr(i, 4, c); wr(i, 5, e);
  endtask

  task automatic all_zero(input string where);
    chk({where, ":pix_valid"},  32'(pix_valid),  32'd0);
    chk({where, ":pix_hit"},    32'(pix_hit),    32'd0);
    chk({where, ":pix_idx"},    32'(pix_idx),    32'd0);
    chk({where, ":pix_color"},  32'(pix_color),  32'd0);
    chk({where, ":hit_mask"},   32'(hit_mask),   32'd0);
    chk({where, ":coll_flags"}, 32'(coll_flags), 32'd0);
    chk({where, ":coll_irq"},   32'(coll_irq),   32'd0);
  endtask

  initial begin
    int we, sel, dat;
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_sel = '0; wr_data = '0;
    frame_start = 1'b0; hpos = '0; vpos = '0; video_on = 1'b0;
    model_reset();
    #2;
    all_zero("por");
    #10 rst_n = 1'b1;

    // Async reset mid-frame with a live box
    box(0, 100, 100, 100, 100, 'h3C, 1);
    fs();
    pix(150, 150); pix(150, 150);
    chk("t1_prereset_hit", 32'(pix_hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    all_zero("t1_async");
    model_reset();
    #8 rst_n = 1'b1;
    fs();
    pix(150, 150); idle(); idle();
    chk("t1_enable_cleared", 32'(pix_hit), 32'd0);

    // Horizontal edges of a single box
    box(0, 100, 100, 100, 100, 'h3C, 1);
    fs();
    pix(99, 150); pix(100, 150);
    chk("t2_h99_hit", 32'(pix_hit), 32'd0);
    pix(199, 150);
    chk("t2_h100_hit", 32'(pix_hit), 32'd1);
    chk("t2_h100_color", 32'(pix_color), 32'h3C);
    pix(200, 150);
    chk("t2_h199_hit", 32'(pix_hit), 32'd1);
    idle();
    chk("t2_h200_hit", 32'(pix_hit), 32'd0);
    chk("t2_h200_color", 32'(pix_color), 32'd0);

    // Overlap priority, sticky flags and single interrupt pulse
    box(0, 100, 100, 100, 100, 'h11, 1);
    box(1, 90, 90, 20, 20, 'h22, 1);
    fs(); idle(); idle();
    pix(105, 105); idle();
    chk("t3_idx", 32'(pix_idx), 32'd0);
    chk("t3_color", 32'(pix_color), 32'h11);
    chk("t3_mask", 32'(hit_mask), 32'b011);
    idle();
    chk("t3_flags", 32'(coll_flags), 32'b011);
    chk("t3_irq_early", 32'(coll_irq), 32'd0);
    idle();
    chk("t3_irq_pulse", 32'(coll_irq), 32'd1);
    idle();
    chk("t3_irq_end", 32'(coll_irq), 32'd0);
    pix(106, 106); idle(); idle(); idle();
    chk("t3_no_refire", 32'(coll_irq), 32'd0);
    chk("t3_flags_hold", 32'(coll_flags), 32'b011);
    fs();
    chk("t3_flags_clear", 32'(coll_flags), 32'd0);

    // Mid-frame write is invisible until commit; same-cycle write goes through
    wr(0, 0, 300);
    pix(105, 150); idle();
    chk("t4_old_x_hit", 32'(pix_hit), 32'd1);
    cyc(105, 150, 1, 1, 1, 0, 0, 150);
    pix(200, 150);
    chk("t4_fs_pixel_old", 32'(pix_hit), 32'd1);
    pix(320, 150);
    chk("t4_through_hit", 32'(pix_hit), 32'd1);
    idle();
    chk("t4_stale_x_miss", 32'(pix_hit), 32'd0);

    // Wrap past the right edge; blanked pixels never collide
    box(1, 1015, 0, 20, 20, 'h22, 1);
    box(2, 1020, 0, 10, 1000, 'h55, 1);
    fs();
    cyc(1023, 10, 0, 0, 0, 0, 0, 0); idle();
    chk("t5_blank_hit", 32'(pix_hit), 32'd0);
    chk("t5_blank_mask", 32'(hit_mask), 32'd0);
    idle(); idle();
    chk("t5_blank_coll", 32'(coll_flags), 32'd0);
    wr(1, 5, 0);
    fs();
    pix(1023, 10); pix(5, 10);
    chk("t5_h1023_hit", 32'(pix_hit), 32'd1);
    chk("t5_h1023_idx", 32'(pix_idx), 32'd2);
    chk("t5_h1023_color", 32'(pix_color), 32'h55);
    pix(6, 10);
    chk("t5_h5_hit", 32'(pix_hit), 32'd1);
    idle();
    chk("t5_h6_hit", 32'(pix_hit), 32'd0);

    // Zero width and dropped writes
    box(1, 0, 0, 0, 1000, 'h22, 1);
    fs();
    pix(0, 5); idle();
    chk("t6_zero_width_mask", 32'(hit_mask), 32'b100);
    wr(3, 0, 700);
    wr(2, 7, 0);
    wr(2, 6, 0);
    fs();
    pix(1023, 10); idle();
    chk("t6_box2_hit", 32'(pix_hit), 32'd1);
    chk("t6_box2_color", 32'(pix_color), 32'h55);
    pix(200, 150); idle();
    chk("t6_box0_idx", 32'(pix_idx), 32'd0);
    chk("t6_box0_color", 32'(pix_color), 32'h11);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      we  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      sel = int'($urandom_range(0, 7));
      dat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                         : int'($urandom_range(0, 255));
      if (sel == 5) dat = ($urandom_range(0, 3) == 0) ? 0 : 1;
      cyc(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 4) != 0) ? 1 : 0,
          ($urandom_range(0, 40) == 0) ? 1 : 0,
          we, int'($urandom_range(0, 3)), sel, dat);
    end
    idle(); idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/box_layer_engine.md
Name: box_layer_engine

Overview:
- Parametrised multi-box renderer. Evaluates NUM_BOXES rectangles against the beam position every pixel clock.
- Outputs a registered pixel colour from the highest-priority box, plus per-box hit and collision flags.
- Box attributes are double-buffered and commit only at frame start, so a CPU/game FSM can update them mid-frame without tearing.
- Sits between gen_sync (hpos/vpos/video_on) and the colour mux feeding the VGA output.

Parameters:
NUM_BOXES, 4, number of box channels (2..16); index 0 has highest priority.
COORD_W, 10, width of coordinates and sizes.
COLOR_W, 8, width of per-box colour.
IDX_W, $clog2(NUM_BOXES), width of box index.

Ports:
clk  in  1  pixel clock.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  attribute write strobe.
wr_idx  in  IDX_W  target box.
wr_sel  in  3  attribute select: 0 xpos, 1 ypos, 2 width, 3 height, 4 color, 5 enable; 6-7 ignored.
wr_data  in  COORD_W  write data; color uses low COLOR_W bits, enable uses bit 0.
frame_start  in  1  one-cycle pulse at the start of each frame.
hpos  in  COORD_W  beam x.
vpos  in  COORD_W  beam y.
video_on  in  1  active display area.
pix_valid  out  1  registered video_on, delayed 2 cycles.
pix_hit  out  1  at least one enabled box covers the pixel.
pix_idx  out  IDX_W  lowest-index hit box; 0 when pix_hit=0.
pix_color  out  COLOR_W  colour of pix_idx; 0 when pix_hit=0.
hit_mask  out  NUM_BOXES  per-box hit, aligned with pix_*.
coll_flags  out  NUM_BOXES  sticky per-box collision flags for the current frame.
coll_irq  out  1  one-cycle pulse when coll_flags goes from all-zero to non-zero.

Behaviour:
- Reset (async, rst_n=0): all shadow and active attributes 0 (every enable=0), pipeline registers 0, and all outputs 0.
- Writes: on clk with wr_en=1, shadow[wr_idx].attr[wr_sel] <= wr_data. Writes with wr_idx >= NUM_BOXES or wr_sel >= 6 are dropped.
- Commit: on a frame_start cycle, active <= shadow, including any write in the same cycle (write-through to active).
- Hit test, per box, modular COORD_W arithmetic:
  - hdiff = hpos - xpos, vdiff = vpos - ypos.
  - hit = enable && hdiff < width && vdiff < height.
  - width=0 or height=0 never hits.
  - A box extending past 2^COORD_W-1 wraps to coordinate 0; this is intended.
- Stage 1 (cycle +1): register raw hit vector ANDed with video_on, plus video_on.
- Stage 2 (cycle +2): priority-encode the lowest set index, drive pix_* and hit_mask. Total latency 2 cycles from hpos/vpos/video_on to outputs.
- Collision:
  - When the stage-2 hit_mask has 2 or more bits set, OR the hit_mask into coll_flags.
  - frame_start clears coll_flags. If a collision is registered in the same cycle, the new bits are set (set wins over clear).
- coll_irq: asserted exactly one cycle, in the cycle after coll_flags changes from 0 to non-zero. It does not re-fire until coll_flags has been cleared.
- Pixels already in the pipeline at frame_start are evaluated with the old attributes (commit affects stage 1 from the next cycle).
- No combinational path from any input to any output.

Test Plan:
1. Reset with rst_n=0 mid-frame while boxes are enabled -> all outputs 0 immediately (async), and enables stay 0 after release.
2. Box 0 at (100,100), size 100x100, colour 0x3C, enable, then frame_start. Sweep hpos=99,100,199,200 at vpos=150 -> pix_hit = 0,1,1,0 two cycles later; pix_color=0x3C on hits.
3. Box 0 at (100,100) 100x100 colour 0x11; box 1 at (90,90) 20x20 colour 0x22; both enabled. At (105,105) -> pix_idx=0, pix_color=0x11, hit_mask=0b0011, coll_flags=0b0011, coll_irq pulses once. A second overlap pixel gives no further pulse. After frame_start, coll_flags=0.
4. Write xpos=300 to box 0 mid-frame -> rendering keeps xpos=100 until frame_start. A write in the same cycle as frame_start takes effect from the next cycle.
5. Box at xpos=1020, width=10, COORD_W=10 -> hits at hpos=1023 and hpos=5, none at hpos=6. video_on=0 -> pix_hit=0 and no collision recorded.
6. Width=0, and writes with wr_sel=7 or out-of-range wr_idx (NUM_BOXES=3) -> never hits, and the invalid writes leave all attributes unchanged.
